// File: rtl/fir_filter_mc.sv
// Multi-channel time-multiplexed FIR with one shared, pipelined MAC and round-half-up output scaling.
// Build option FIR_FILTER_MC_SATURATE_EN clamps the scaled result; otherwise it wraps to DATA_WIDTH.

module fir_filter_mc #(
    parameter int DATA_WIDTH = 24,
    parameter int COEF_WIDTH = 18,
    parameter int FIR_DEPTH  = 16,
    parameter int NUM_CH     = 2,
    parameter int OUT_SHIFT  = 17,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned TAP_W = $clog2(FIR_DEPTH)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_en,
    input  logic signed [DATA_WIDTH-1:0] iv_din,
    input  logic        [CH_W-1:0]       iv_din_ch,
    input  logic                         i_din_valid,
    output logic                         o_din_ready,
    input  logic signed [COEF_WIDTH-1:0] iv_coef,
    input  logic        [TAP_W-1:0]      iv_coef_addr,
    input  logic                         i_coef_we,
    output logic signed [DATA_WIDTH-1:0] ov_dout,
    output logic        [CH_W-1:0]       ov_dout_ch,
    output logic                         o_dout_valid,
    input  logic                         i_dout_ready
);

    localparam int unsigned ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + TAP_W;
    localparam int unsigned PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;
    localparam int unsigned NUM_CH_U   = NUM_CH;
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(FIR_DEPTH - 1);
    localparam logic signed [ACC_WIDTH-1:0] RND = ACC_WIDTH'(1) <<< (OUT_SHIFT - 1);
`ifdef FIR_FILTER_MC_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
`endif

    typedef enum logic [2:0] {S_IDLE, S_MAC, S_DRAIN, S_FIN, S_OUT} state_t;

    state_t                         state_q, state_d;
    logic        [CH_W-1:0]         ch_q, ch_d;
    logic        [TAP_W-1:0]        pos_q, pos_d;
    logic        [TAP_W-1:0]        k_q, k_d;
    logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic signed [PROD_WIDTH-1:0]   prod_q, prod_d;
    logic                           pv_q, pv_d;
    logic signed [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic        [CH_W-1:0]         dout_ch_q, dout_ch_d;
    logic                           dout_valid_q, dout_valid_d;
    logic signed [DATA_WIDTH-1:0]   x_q [NUM_CH][FIR_DEPTH];
    logic signed [DATA_WIDTH-1:0]   x_d [NUM_CH][FIR_DEPTH];
    logic signed [COEF_WIDTH-1:0]   coef_q [FIR_DEPTH];
    logic signed [COEF_WIDTH-1:0]   coef_d [FIR_DEPTH];
    logic        [TAP_W-1:0]        head_q [NUM_CH];
    logic        [TAP_W-1:0]        head_d [NUM_CH];

    logic                           in_range_c;
    logic signed [ACC_WIDTH-1:0]    sum_c;
    logic signed [ACC_WIDTH-1:0]    scaled_c;
    logic signed [DATA_WIDTH-1:0]   narrow_c;

    assign o_din_ready  = (state_q == S_IDLE) & i_en;
    assign ov_dout      = dout_q;
    assign ov_dout_ch   = dout_ch_q;
    assign o_dout_valid = dout_valid_q;

    assign in_range_c = 32'(iv_din_ch) < NUM_CH_U;

    // Round half up, arithmetic shift, then narrow to the output width.
    always_comb begin
        sum_c    = acc_q + RND;
        scaled_c = sum_c >>> OUT_SHIFT;
`ifdef FIR_FILTER_MC_SATURATE_EN
        if (scaled_c > SAT_MAX) begin
            narrow_c = SAT_MAX[DATA_WIDTH-1:0];
        end else if (scaled_c < SAT_MIN) begin
            narrow_c = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            narrow_c = scaled_c[DATA_WIDTH-1:0];
        end
`else
        narrow_c = scaled_c[DATA_WIDTH-1:0];
`endif
    end

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        pos_d        = pos_q;
        k_d          = k_q;
        acc_d        = acc_q;
        prod_d       = prod_q;
        pv_d         = pv_q;
        dout_d       = dout_q;
        dout_ch_d    = dout_ch_q;
        dout_valid_d = dout_valid_q;
        x_d          = x_q;
        coef_d       = coef_q;
        head_d       = head_q;
        if (i_en) begin
            case (state_q)
                S_IDLE: begin
                    if (i_coef_we) begin
                        coef_d[iv_coef_addr] = iv_coef;
                    end
                    // Out-of-range channels are consumed without touching any history.
                    if (i_din_valid && in_range_c) begin
                        x_d[iv_din_ch][head_q[iv_din_ch]] = iv_din;
                        head_d[iv_din_ch] = (head_q[iv_din_ch] == LAST_TAP) ?
                                            '0 : head_q[iv_din_ch] + TAP_W'(1);
                        ch_d    = iv_din_ch;
                        pos_d   = head_q[iv_din_ch];
                        k_d     = '0;
                        acc_d   = '0;
                        pv_d    = 1'b0;
                        state_d = S_MAC;
                    end
                end
                S_MAC: begin
                    prod_d = PROD_WIDTH'(x_q[ch_q][pos_q]) * PROD_WIDTH'(coef_q[k_q]);
                    pv_d   = 1'b1;
                    if (pv_q) begin
                        acc_d = acc_q + ACC_WIDTH'(prod_q);
                    end
                    pos_d = (pos_q == '0) ? LAST_TAP : pos_q - TAP_W'(1);
                    k_d   = k_q + TAP_W'(1);
                    if (k_q == LAST_TAP) begin
                        state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    acc_d   = acc_q + ACC_WIDTH'(prod_q);
                    pv_d    = 1'b0;
                    state_d = S_FIN;
                end
                S_FIN: begin
                    dout_d       = narrow_c;
                    dout_ch_d    = ch_q;
                    dout_valid_d = 1'b1;
                    state_d      = S_OUT;
                end
                S_OUT: begin
                    if (i_dout_ready) begin
                        dout_valid_d = 1'b0;
                        state_d      = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            ch_q         <= '0;
            pos_q        <= '0;
            k_q          <= '0;
            acc_q        <= '0;
            prod_q       <= '0;
            pv_q         <= 1'b0;
            dout_q       <= '0;
            dout_ch_q    <= '0;
            dout_valid_q <= 1'b0;
            x_q          <= '{default: '0};
            coef_q       <= '{default: '0};
            head_q       <= '{default: '0};
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            pos_q        <= pos_d;
            k_q          <= k_d;
            acc_q        <= acc_d;
            prod_q       <= prod_d;
            pv_q         <= pv_d;
            dout_q       <= dout_d;
            dout_ch_q    <= dout_ch_d;
            dout_valid_q <= dout_valid_d;
            x_q          <= x_d;
            coef_q       <= coef_d;
            head_q       <= head_d;
        end
    end

endmodule

// File: tb/tb_fir_filter_mc.sv
// Self-checking bench for fir_filter_mc: vector table, scoreboard queue and multi-cycle corner sequences.
// Three channels are configured so the 2-bit channel index can carry the unused value 3.

module tb_fir_filter_mc;

    localparam int DW  = 24;
    localparam int CW  = 18;
    localparam int D   = 4;
    localparam int NCH = 3;
    localparam int SH  = 1;
    localparam int CHW = 2;
    localparam int TW  = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 en = 1'b1;
    logic signed [DW-1:0] din = '0;
    logic [CHW-1:0]       din_ch = '0;
    logic                 din_valid = 1'b0;
    logic                 din_ready;
    logic signed [CW-1:0] coef = '0;
    logic [TW-1:0]        coef_addr = '0;
    logic                 coef_we = 1'b0;
    logic signed [DW-1:0] dout;
    logic [CHW-1:0]       dout_ch;
    logic                 dout_valid;
    logic                 dout_ready = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    longint exp_q[$];
    int     exp_ch_q[$];

    typedef struct {
        int     ch;
        int     din;
        longint exp;
    } vec_t;

    vec_t vecs [16];

    always #5 clk = ~clk;

    fir_filter_mc #(
        .DATA_WIDTH(DW), .COEF_WIDTH(CW), .FIR_DEPTH(D), .NUM_CH(NCH), .OUT_SHIFT(SH)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en),
        .iv_din(din), .iv_din_ch(din_ch), .i_din_valid(din_valid), .o_din_ready(din_ready),
        .iv_coef(coef), .iv_coef_addr(coef_addr), .i_coef_we(coef_we),
        .ov_dout(dout), .ov_dout_ch(dout_ch), .o_dout_valid(dout_valid), .i_dout_ready(dout_ready)
    );

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input int k, input int v);
        coef_we   = 1'b1;
        coef_addr = TW'(k);
        coef      = CW'(v);
        tick();
        coef_we   = 1'b0;
    endtask

    task automatic load_h(input int h0, input int h1, input int h2, input int h3);
        write_coef(0, h0);
        write_coef(1, h1);
        write_coef(2, h2);
        write_coef(3, h3);
    endtask

    // Independent reference for the scaling path: round half up, shift, then clamp or wrap.
    function automatic longint scale(input longint acc);
        longint r;
        logic signed [DW-1:0] t;
        r = (acc + (longint'(1) <<< (SH - 1))) >>> SH;
`ifdef FIR_FILTER_MC_SATURATE_EN
        if (r > (longint'(1) <<< (DW - 1)) - 1) r = (longint'(1) <<< (DW - 1)) - 1;
        if (r < -(longint'(1) <<< (DW - 1)))    r = -(longint'(1) <<< (DW - 1));
        return r;
`else
        t = DW'(r);
        return longint'(t);
`endif
    endfunction

    // One sample end to end: accept, optional freeze, latency, optional backpressure, handshake.
    task automatic run_sample(input int v_ch, input int v_din, input longint v_exp,
                              input int exp_lat, input int freeze_at, input int bp);
        int n;
        longint held;
        longint e;
        int ec;
        n = 0;
        while (!din_ready && n < 100) begin
            tick();
            n++;
        end
        check("din_ready_before_accept", din_ready, 1);
        din_valid = 1'b1;
        din       = DW'(v_din);
        din_ch    = CHW'(v_ch);
        tick();
        din_valid = 1'b0;
        coef_we   = 1'b0;
        if (v_ch >= NCH) begin
            n = 0;
            repeat (D + 4) begin
                if (dout_valid) n++;
                tick();
            end
            check("oor_no_output", n, 0);
            check("oor_din_ready", din_ready, 1);
            return;
        end
        exp_q.push_back(v_exp);
        exp_ch_q.push_back(v_ch);
        n = 0;
        while (!dout_valid && n < 100) begin
            if (n == freeze_at) begin
                en = 1'b0;
                repeat (5) tick();
                n += 5;
                check("freeze_no_valid", dout_valid, 0);
                en = 1'b1;
            end
            tick();
            n++;
        end
        check("latency", n, exp_lat);
        if (bp > 0) begin
            held = longint'(dout);
            for (int i = 0; i < bp; i++) begin
                coef_we   = 1'b1;
                coef_addr = TW'(i);
                coef      = CW'(77 + i);
                tick();
                check("bp_valid_hold", dout_valid, 1);
                check("bp_dout_hold", longint'(dout), held);
                check("bp_din_ready_low", din_ready, 0);
            end
            coef_we = 1'b0;
        end
        dout_ready = 1'b1;
        e  = exp_q.pop_front();
        ec = exp_ch_q.pop_front();
        check("dout_value", longint'(dout), e);
        check("dout_ch", dout_ch, ec);
        tick();
        dout_ready = 1'b0;
        check("valid_drop", dout_valid, 0);
        check("din_ready_after", din_ready, 1);
    endtask

    initial begin
        int n;
        vecs[0]  = '{0, 1000, 500};
        vecs[1]  = '{0, 0, 1000};
        vecs[2]  = '{0, 0, 1500};
        vecs[3]  = '{0, 0, 2000};
        vecs[4]  = '{0, 1000, 500};
        vecs[5]  = '{1, -2000, -1000};
        vecs[6]  = '{0, 0, 1000};
        vecs[7]  = '{1, 0, -2000};
        vecs[8]  = '{0, 0, 1500};
        vecs[9]  = '{1, 0, -3000};
        vecs[10] = '{0, 0, 2000};
        vecs[11] = '{1, 0, -4000};
        vecs[12] = '{3, 5555, 0};
        vecs[13] = '{0, 0, 0};
        vecs[14] = '{1, 3, 2};
        vecs[15] = '{1, -7, 0};

        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", dout_valid, 0);
        check("rst_dout", longint'(dout), 0);
        check("rst_dout_ch", dout_ch, 0);
        check("rst_din_ready", din_ready, 1);

        load_h(1, 2, 3, 4);
        for (int i = 0; i < 16; i++) begin
            run_sample(vecs[i].ch, vecs[i].din, vecs[i].exp, 6, -1, 0);
        end

        // Backpressure with ignored coefficient writes, then readback through the next output.
        run_sample(0, 1000, 500, 6, -1, 10);
        run_sample(0, 0, 1000, 6, -1, 0);

        // Enable dropped for 5 cycles mid-MAC.
        run_sample(0, 0, 1500, 11, 2, 0);

        // Coefficient write on the accept edge is used by that sample.
        coef_we   = 1'b1;
        coef_addr = TW'(3);
        coef      = CW'(10);
        run_sample(0, 0, 5000, 6, -1, 0);

        // Reset three cycles after accept discards the result and clears all state.
        din_valid = 1'b1;
        din       = DW'(1234);
        din_ch    = CHW'(1);
        tick();
        din_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", dout_valid, 0);
        check("midrst_dout", longint'(dout), 0);
        check("midrst_din_ready", din_ready, 1);
        n = 0;
        repeat (12) begin
            if (dout_valid) n++;
            tick();
        end
        check("midrst_no_output", n, 0);
        load_h(1, 2, 3, 4);
        run_sample(0, 1000, 500, 6, -1, 0);
        run_sample(0, 0, 1000, 6, -1, 0);
        run_sample(1, 0, 0, 6, -1, 0);

        // Full-scale inputs and coefficients overflow the output width.
        load_h(131071, 131071, 131071, 131071);
        for (int i = 1; i <= 4; i++) begin
            run_sample(1, 8388607, scale(longint'(i) * 131071 * 8388607), 6, -1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
